// File: rtl/qos_wrr_param_if.sv
// Ingress write port and egress valid/ready port of the parametrised QoS WRR block.
// The block drives the slave side; the traffic source/sink uses the master side.
interface qos_wrr_param_if #(
    parameter int NUM_VC = 4,
    parameter int DATA_W = 8
);
    logic                      in_valid;
    logic [$clog2(NUM_VC)-1:0] in_vc;
    logic [DATA_W-1:0]         in_data;
    logic                      out_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [$clog2(NUM_VC)-1:0] out_vc;

    modport master (
        output in_valid, in_vc, in_data, out_ready,
        input  out_valid, out_data, out_vc
    );

    modport slave (
        input  in_valid, in_vc, in_data, out_ready,
        output out_valid, out_data, out_vc
    );
endinterface

// File: rtl/qos_wrr_param.sv
// NUM_VC per-VC FIFOs drained by a weighted round-robin arbiter into one registered output.
// Define QOS_STRICT_PRIO_EN to give VC0 strict priority over the WRR members.
module qos_wrr_param #(
    parameter int NUM_VC   = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int WEIGHT_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    qos_wrr_param_if.slave             bus,
    input  logic [NUM_VC*WEIGHT_W-1:0] weights,
    input  logic [$clog2(DEPTH):0]     umbral_max,
    input  logic [$clog2(DEPTH):0]     umbral_min,
    input  logic                       err_clr,
    output logic [NUM_VC-1:0]          pausa,
    output logic [NUM_VC-1:0]          error_full,
    output logic                       idle
);
    localparam int VW = $clog2(NUM_VC);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0]   mem       [NUM_VC][DEPTH];
    logic [PW-1:0]       wr_ptr    [NUM_VC];
    logic [PW-1:0]       rd_ptr    [NUM_VC];
    logic [CW-1:0]       count     [NUM_VC];
    logic [CW-1:0]       count_nxt [NUM_VC];
    logic [WEIGHT_W-1:0] weight    [NUM_VC];
    logic [VW-1:0]       cur, cur_nxt, pop_vc, rr_vc, cand;
    logic [WEIGHT_W-1:0] credit, credit_nxt;
    logic [NUM_VC-1:0]   nonempty, push_vec, pop_vec, ovf_vec;
    logic                load, prio0, all_empty;

    always_comb begin
        all_empty = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            weight[v]   = weights[v*WEIGHT_W +: WEIGHT_W];
            nonempty[v] = (count[v] != '0);
            if (nonempty[v]) all_empty = 1'b0;
        end
    end

    assign idle = all_empty && !bus.out_valid;

    // Scan downward so the closest non-empty VC after cur is the one that sticks.
    always_comb begin
        rr_vc = cur;
        cand  = cur;
        for (int i = NUM_VC; i >= 1; i--) begin
            cand = VW'((int'(cur) + i) % NUM_VC);
            if (nonempty[cand]) rr_vc = cand;
        end
    end

    always_comb begin
        load  = enb && (!bus.out_valid || bus.out_ready) && !all_empty;
        prio0 = 1'b0;
`ifdef QOS_STRICT_PRIO_EN
        prio0 = nonempty[0];
`endif
        pop_vc     = cur;
        cur_nxt    = cur;
        credit_nxt = credit;
        if (prio0) begin
            pop_vc = '0;
        end else if (nonempty[cur] && credit != '0) begin
            credit_nxt = credit - WEIGHT_W'(1);
        end else begin
            pop_vc     = rr_vc;
            cur_nxt    = rr_vc;
            credit_nxt = (weight[rr_vc] == '0) ? '0 : weight[rr_vc] - WEIGHT_W'(1);
        end
    end

    // A pop on the same VC frees the slot, so a write to a full VC still lands.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            pop_vec[v]  = load && (pop_vc == VW'(v));
            push_vec[v] = 1'b0;
            ovf_vec[v]  = 1'b0;
            if (enb && bus.in_valid && bus.in_vc == VW'(v)) begin
                if (count[v] != CW'(DEPTH) || pop_vec[v]) push_vec[v] = 1'b1;
                else                                      ovf_vec[v]  = 1'b1;
            end
            count_nxt[v] = count[v] + CW'(push_vec[v]) - CW'(pop_vec[v]);
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_vec[v]) mem[v][wr_ptr[v]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                count[v]  <= '0;
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            cur           <= VW'(NUM_VC - 1);
            credit        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_vc    <= '0;
            pausa         <= '0;
            error_full    <= '0;
        end else if (enb) begin
            for (int v = 0; v < NUM_VC; v++) begin
                count[v] <= count_nxt[v];
                if (push_vec[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
                if (pop_vec[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
                if (count_nxt[v] >= umbral_max)      pausa[v] <= 1'b1;
                else if (count_nxt[v] <= umbral_min) pausa[v] <= 1'b0;
            end
            error_full <= (err_clr ? '0 : error_full) | ovf_vec;
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= mem[pop_vc][rd_ptr[pop_vc]];
                bus.out_vc    <= pop_vc;
                cur           <= cur_nxt;
                credit        <= credit_nxt;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
